// File: rtl/cpu_pkg.sv
// Shared types for the cpu core, its run controller and the bench.
// The state encoding is fixed so the debug output reads the same everywhere.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  localparam int RST_CNT_W = 8;

  // Once released, the core stays out of reset until a new run begins,
  // so its state can still be inspected after a halt or a timeout.
  function automatic logic core_released(input run_state_t s);
    return (s == RUN) || (s == HALTED) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down-counter that stops at zero.
// It flags expiry on the last counted cycle, so the caller can leave on that edge.
module sat_down_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count <= W'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the cpu core: sequences core reset, gates execution
// (free-run or single-step), counts enabled cycles and ends on halt or timeout.
module cpu_run_ctrl #(
  parameter int RST_CYCLES = 1,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             hlt,
  output logic             cpu_rst_n,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             timed_out,
  output logic [2:0]       state
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0]     TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [RST_CNT_W-1:0] RST_LOAD    = RST_CNT_W'(RST_CYCLES);

  run_state_t       r_state;
  run_state_t       w_next;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_cpu_rst_n;
  logic             w_en;
  logic             w_load_rst;
  logic             w_dec_rst;
  logic             w_rst_expired;

  sat_down_counter #(
    .W(RST_CNT_W)
  ) u_rst_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_load_rst),
    .i_load_val (RST_LOAD),
    .i_dec      (w_dec_rst),
    .o_expired  (w_rst_expired)
  );

  assign w_cnt_inc = r_cycle_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_rst_n <= core_released(w_next);
    end
  end

  // Halt takes priority over reaching the cycle budget on the same edge.
  always_comb begin
    w_next     = r_state;
    w_en       = 1'b0;
    w_load_rst = 1'b0;
    w_dec_rst  = 1'b0;
    case (r_state)
      IDLE, HALTED, cpu_pkg::TIMEOUT: begin
        if (start) begin
          w_next     = RESET;
          w_load_rst = 1'b1;
        end
      end
      RESET: begin
        w_dec_rst = 1'b1;
        if (w_rst_expired) begin
          w_next = RUN;
        end
      end
      RUN: begin
        w_en = !step_mode || step;
        if (hlt) begin
          w_next = HALTED;
        end else if (w_en && (w_cnt_inc == TIMEOUT_VAL)) begin
          w_next = cpu_pkg::TIMEOUT;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The count is cleared as a new run begins, then frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (w_load_rst) begin
      r_cycle_cnt <= '0;
    end else if (w_en) begin
      r_cycle_cnt <= w_cnt_inc;
    end
  end

  assign cpu_rst_n = r_cpu_rst_n;
  assign cpu_en    = w_en;
  assign cycle_cnt = r_cycle_cnt;
  assign done      = (r_state == HALTED);
  assign timed_out = (r_state == cpu_pkg::TIMEOUT);
  assign state     = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed vector table, hand-written
// reset corner cases, then randomized traffic against a run-level model.
module tb_cpu_run_ctrl;
  import cpu_pkg::*;

  localparam int TB_RST_CYCLES = 3;
  localparam int TB_CNT_W      = 16;
  localparam int TB_TIMEOUT    = 10;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                step_mode;
  logic                step;
  logic                hlt;
  logic                cpu_rst_n;
  logic                cpu_en;
  logic [TB_CNT_W-1:0] cycle_cnt;
  logic                done;
  logic                timed_out;
  logic [2:0]          state;

  int checks;
  int failures;

  typedef struct {
    logic       start;
    logic       stepMode;
    logic       step;
    logic       hlt;
    logic       expEn;
    run_state_t expState;
    int         expCnt;
    logic       expRstN;
  } vec_t;

  vec_t vecs[$];

  run_state_t mState;
  int         mRstLeft;
  int         mCnt;
  logic       enSeen;
  int         stepEnCount;

  cpu_run_ctrl #(
    .RST_CYCLES(TB_RST_CYCLES),
    .CNT_W     (TB_CNT_W),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .hlt       (hlt),
    .cpu_rst_n (cpu_rst_n),
    .cpu_en    (cpu_en),
    .cycle_cnt (cycle_cnt),
    .done      (done),
    .timed_out (timed_out),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRegs(input string tag, input run_state_t es, input int ec, input logic er);
    checkOutput({tag, "_state"}, int'(state), int'(es));
    checkOutput({tag, "_cnt"}, int'(cycle_cnt), ec);
    checkOutput({tag, "_cpu_rst_n"}, int'(cpu_rst_n), int'(er));
    checkOutput({tag, "_done"}, int'(done), int'(es == HALTED));
    checkOutput({tag, "_timed_out"}, int'(timed_out), int'(es == TIMEOUT));
  endtask

  // Called just after a rising edge: drive inputs, sample the enable, take one edge.
  task automatic applyStimulus(input logic s, input logic sm, input logic st, input logic h,
                               output logic en);
    start     = s;
    step_mode = sm;
    step      = st;
    hlt       = h;
    #1;
    en = cpu_en;
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic s, input logic sm, input logic st, input logic h,
                                 input logic en, input run_state_t es, input int ec,
                                 input logic er);
    vec_t v;
    v.start    = s;
    v.stepMode = sm;
    v.step     = st;
    v.hlt      = h;
    v.expEn    = en;
    v.expState = es;
    v.expCnt   = ec;
    v.expRstN  = er;
    vecs.push_back(v);
  endfunction

  function automatic void addResetPhase(input logic hltInReset);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RESET, 0, 1'b0);
    for (int i = 1; i < TB_RST_CYCLES; i++)
      addVec(1'b0, 1'b0, 1'b0, hltInReset, 1'b0, RESET, 0, 1'b0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 0, 1'b1);
  endfunction

  // Run-level model: a run is a reset window of RST_CYCLES edges followed by
  // counted enabled cycles until halt or the budget is used up.
  function automatic void modelEdge(input logic s, input logic sm, input logic st, input logic h);
    logic en;
    en = (mState == RUN) && (!sm || st);
    if (mState == IDLE || mState == HALTED || mState == TIMEOUT) begin
      if (s) begin
        mState   = RESET;
        mRstLeft = TB_RST_CYCLES;
        mCnt     = 0;
      end
    end else if (mState == RESET) begin
      mRstLeft = mRstLeft - 1;
      if (mRstLeft == 0) mState = RUN;
    end else begin
      if (en) mCnt = mCnt + 1;
      if (h) mState = HALTED;
      else if (en && mCnt == TB_TIMEOUT) mState = TIMEOUT;
    end
  endfunction

  function automatic logic modelRstN();
    return (mState == RUN) || (mState == HALTED) || (mState == TIMEOUT);
  endfunction

  initial begin
    logic s, sm, st, h, expEn;
    checks      = 0;
    failures    = 0;
    stepEnCount = 0;

    // Reset held for 3 cycles with start and hlt asserted: both must be ignored.
    rst_n     = 1'b0;
    start     = 1'b1;
    hlt       = 1'b1;
    step_mode = 1'b0;
    step      = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkRegs("por", IDLE, 0, 1'b0);
      checkOutput("por_cpu_en", int'(cpu_en), 0);
    end
    start = 1'b0;
    hlt   = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("post_por", IDLE, 0, 1'b0);

    // Run 1: reset sequencing, start ignored in RUN, halt in the 7th enabled cycle.
    addResetPhase(1'b1);
    for (int k = 1; k <= 6; k++)
      addVec(k == 4, 1'b0, 1'b0, 1'b0, 1'b1, RUN, k, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, HALTED, 7, 1'b1);
    for (int i = 0; i < 5; i++)
      addVec(1'b0, 1'b0, 1'b0, i == 2, 1'b0, HALTED, 7, 1'b1);
    // Run 2: budget exhausted; step has no effect in free-run.
    addResetPhase(1'b0);
    for (int k = 1; k < TB_TIMEOUT; k++)
      addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, RUN, k, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, TIMEOUT, TB_TIMEOUT, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TIMEOUT, TB_TIMEOUT, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, TIMEOUT, TB_TIMEOUT, 1'b1);
    // Run 3: halt on the same edge the budget is reached.
    addResetPhase(1'b0);
    for (int k = 1; k < TB_TIMEOUT; k++)
      addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, k, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, HALTED, TB_TIMEOUT, 1'b1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HALTED, TB_TIMEOUT, 1'b1);
    // Run 4: single-step, four pulses separated by idle cycles, then a fifth.
    addResetPhase(1'b0);
    addVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RUN, 1, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 1, 1'b1);
    addVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RUN, 2, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 2, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 2, 1'b1);
    addVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RUN, 3, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 3, 1'b1);
    addVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RUN, 4, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 4, 1'b1);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RUN, 4, 1'b1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].stepMode, vecs[i].step, vecs[i].hlt, enSeen);
      checkOutput($sformatf("vec%0d_cpu_en", i), int'(enSeen), int'(vecs[i].expEn));
      checkRegs($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expCnt, vecs[i].expRstN);
      if (vecs[i].stepMode && enSeen) stepEnCount++;
    end
    checkOutput("step_en_cycles", stepEnCount, 4);

    // Mid-run: bring the count to 5, show start is ignored, then reset asynchronously.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, enSeen);
    checkRegs("midrun_cnt5", RUN, 5, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, enSeen);
    checkRegs("midrun_start_ignored", RUN, 5, 1'b1);
    start     = 1'b0;
    step_mode = 1'b0;
    #2;
    checkOutput("midrun_pre_en", int'(cpu_en), 1);
    rst_n = 1'b0;
    #1;
    checkRegs("midrun_async", IDLE, 0, 1'b0);
    checkOutput("midrun_async_en", int'(cpu_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("midrun_release", IDLE, 0, 1'b0);

    // Randomized traffic against the model, with occasional asynchronous resets.
    mState   = IDLE;
    mRstLeft = 0;
    mCnt     = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        start = 1'b0;
        hlt   = 1'b0;
        step  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mState = IDLE;
        mCnt   = 0;
        checkRegs($sformatf("rnd%0d_arst", c), mState, mCnt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      s  = ($urandom_range(0, 7) == 0);
      sm = ($urandom_range(0, 9) < 3);
      st = $urandom_range(0, 1) == 1;
      h  = ($urandom_range(0, 15) == 0);
      expEn = (mState == RUN) && (!sm || st);
      applyStimulus(s, sm, st, h, enSeen);
      modelEdge(s, sm, st, h);
      checkOutput($sformatf("rnd%0d_cpu_en", c), int'(enSeen), int'(expEn));
      checkRegs($sformatf("rnd%0d", c), mState, mCnt, modelRstN());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable, parametrised run controller that sits between the board/bench clock-reset domain and the `cpu` core. It sequences the core's reset, gates execution through a clock-enable (free-run or single-step), counts executed cycles, and terminates a run on `hlt` or on a cycle-budget timeout. It replaces the fixed-delay reset/finish sequencing of the CPU bench with deterministic, observable run control usable in both simulation and FPGA bring-up.

## Interface
Parameters:
- `RST_CYCLES`, 1: cycles `cpu_rst_n` is held low after `start`; legal range 1..255.
- `CNT_W`, 16: width of the cycle counter.
- `TIMEOUT`, 10: maximum number of enabled cycles per run; legal range 1..2^CNT_W-1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset for this block.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE, HALTED or TIMEOUT.
- `step_mode`  in  1  1 = single-step, 0 = free-run; sampled every cycle.
- `step`  in  1  in step mode, enables exactly one CPU cycle per high cycle.
- `hlt`  in  1  halt indication from the core.
- `cpu_rst_n`  out  1  registered, active-low reset to the core.
- `cpu_en`  out  1  core clock-enable.
- `cycle_cnt`  out  CNT_W  enabled cycles executed in the current or last run.
- `done`  out  1  high while in HALTED.
- `timed_out`  out  1  high while in TIMEOUT.
- `state`  out  3  current state encoding, for debug.

## Operation
- States: IDLE, RESET, RUN, HALTED, TIMEOUT.
- IDLE: `cpu_rst_n`=0, `cpu_en`=0. `start` -> RESET.
- RESET: clear `cycle_cnt`; load the reset down-counter with RST_CYCLES; keep `cpu_rst_n`=0. When the counter expires -> RUN, and `cpu_rst_n` goes to 1 on that same edge. `hlt` is ignored in RESET.
- RUN: `cpu_en` = (!`step_mode`) | `step`. This path is combinational from the registered state and inputs.
  - On each edge with `cpu_en`=1, `cycle_cnt` increments by 1.
  - `hlt`=1 on any RUN edge -> HALTED.
  - Otherwise, if the increment makes `cycle_cnt`==TIMEOUT -> TIMEOUT.
  - If both occur on the same edge, `hlt` wins (-> HALTED).
- HALTED and TIMEOUT: `cpu_en`=0; `cpu_rst_n` stays 1 so the core's state remains inspectable; `cycle_cnt` is frozen. `start` -> RESET, which starts a new run.
- `start` in RESET or RUN is ignored.
- `step` while `step_mode`=0 has no additional effect.
- `cycle_cnt` never wraps, because TIMEOUT bounds it.

## Timing
- Asynchronous `rst_n` low forces, immediately: state=IDLE, `cpu_rst_n`=0, `cpu_en`=0, `cycle_cnt`=0, `done`=0, `timed_out`=0, reset down-counter=0. This applies mid-run as well.
- `start` sampled at edge N: state=RESET after N. `cpu_rst_n` is low for exactly RST_CYCLES cycles after that edge, then high together with state=RUN.
- `done` and `timed_out` are decoded from the registered state, so they assert on the same edge the state changes.
- Free-run with `hlt` first high during the k-th enabled cycle: `cycle_cnt`=k and `done`=1 after that edge.

## Structure
- Shared package `cpu_pkg`: state enum `run_state_t` (IDLE=0, RESET=1, RUN=2, HALTED=3, TIMEOUT=4). The `cpu` core and the bench use the same package.
- One sub-module: `sat_down_counter`, which loads RST_CYCLES and flags expiry. The cycle counter stays inline.

## Test plan
- Reset values: hold `rst_n`=0 for 3 cycles. Require all outputs at their reset values and state=0; `hlt`=1 and `start`=1 during reset are ignored.
- Reset sequencing: RST_CYCLES=3, pulse `start`. Require `cpu_rst_n`=0 for exactly 3 cycles, then 1 with state=RUN and `cpu_en`=1.
- Halt: free-run, `hlt` driven high during the 7th enabled cycle. Require `done`=1, `cycle_cnt`=7, `cpu_en`=0, and `cycle_cnt` holding 7 for 5 more cycles.
- Timeout and tie: TIMEOUT=10 with `hlt`=0 gives `timed_out`=1 and `cycle_cnt`=10. A rerun with `hlt` high on the 10th enabled cycle gives `done`=1 and `timed_out`=0.
- Step mode: `step_mode`=1, four 1-cycle `step` pulses separated by idle cycles. Require `cycle_cnt`=4 and `cpu_en` high in exactly 4 cycles.
- Mid-run: assert `rst_n` low while in RUN with `cycle_cnt`=5. Require an immediate return to IDLE with `cycle_cnt`=0. A `start` pulse during RUN causes no change in state or count.
